// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants and types for the memory port arbiter
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W   = 10;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_MAX_WAIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_DATA  = 1'b0,
    OWN_FETCH = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - saturating count of arbitrations lost by the fetch port
module arb_wait_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;

  // clear has priority; increment stops once the limit is reached
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign at_max = (r_cnt == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of a single-port synchronous memory
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  arb_owner_t        r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_flush;

  logic w_idle;
  logic w_any_req;
  logic w_at_max;
  logic w_fetch_win;
  logic w_wait_inc;
  logic w_wait_clr;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_any_req   = if_req | d_req;
  // data normally wins; a starved fetch is forced through once the counter saturates
  assign w_fetch_win = if_req & (~d_req | w_at_max);
  assign w_wait_inc  = w_idle & if_req & d_req & ~w_at_max;
  assign w_wait_clr  = w_idle & w_fetch_win;

  arb_wait_counter #(
    .MAX (MAX_WAIT)
  ) u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (w_wait_inc),
    .clr    (w_wait_clr),
    .at_max (w_at_max)
  );

  // state register plus the request captured at arbitration and the fetch flush flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_DATA;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_idle && w_any_req) begin
        r_owner <= w_fetch_win ? OWN_FETCH : OWN_DATA;
        r_we    <= w_fetch_win ? 1'b0 : d_we;
        r_addr  <= w_fetch_win ? if_addr : d_addr;
        r_wdata <= w_fetch_win ? '0 : d_wdata;
      end
      if (w_idle) begin
        r_flush <= 1'b0;
      end else if ((r_state == ST_ISSUE) && (r_owner == OWN_FETCH) && if_flush) begin
        r_flush <= 1'b1;
      end
    end
  end

  // next-state and all outputs decoded from the registered state
  always_comb begin
    w_next_state = r_state;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    if_rvalid    = 1'b0;
    if_rdata     = '0;
    d_rvalid     = 1'b0;
    d_rdata      = '0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_en       = 1'b1;
        mem_we       = r_we;
        mem_addr     = r_addr;
        mem_wdata    = r_wdata;
        if_gnt       = (r_owner == OWN_FETCH);
        d_gnt        = (r_owner == OWN_DATA);
        w_next_state = r_we ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        if (r_owner == OWN_FETCH) begin
          if (!r_flush && !if_flush) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end
        end else begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
        end
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, if_req, if_flush, d_req, d_we;
  logic [9:0]  if_addr, d_addr;
  logic [31:0] d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic         rst, ifr;
    logic [9:0]   ifa;
    logic         fl, dr, dwe;
    logic [9:0]   da;
    logic [31:0]  dwd;
    logic [111:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [111:0] ex(input logic ig, dg, iv, input logic [31:0] ird,
                                      input logic dv, input logic [31:0] drd,
                                      input logic en, we, input logic [9:0] ma,
                                      input logic [31:0] wd);
    return {ig, dg, iv, ird, dv, drd, en, we, ma, wd};
  endfunction

  function automatic vec_t mk(input logic r, ifr, input logic [9:0] ifa, input logic fl, dr, dwe,
                              input logic [9:0] da, input logic [31:0] dwd, input logic [111:0] e);
    vec_t v;
    v.rst = r; v.ifr = ifr; v.ifa = ifa; v.fl = fl; v.dr = dr; v.dwe = dwe;
    v.da = da; v.dwd = dwd; v.exp = e;
    return v;
  endfunction

  task automatic drive(input logic r, ifr, input logic [9:0] ifa, input logic fl, dr, dwe,
                       input logic [9:0] da, input logic [31:0] dwd);
    rst = r; if_req = ifr; if_addr = ifa; if_flush = fl;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
  endtask

  logic [111:0] z, act;
  logic [31:0]  beef;
  byte          grants[$];
  byte          exp_g;
  int           both_cnt;

  initial begin
    beef = 32'hDEADBEEF;
    mem[5] = beef;
    mem_rdata = '0;
    z = ex(0,0,0,0,0,0,0,0,0,0);

    vecs.push_back(mk(1,0,0,0,0,0, 0,0,      z));                              // 0 reset
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      z));                              // 1 idle
    vecs.push_back(mk(0,1,5,0,0,0, 0,0,      z));                              // 2 fetch req
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      ex(1,0,0,0,0,0,1,0,5,0)));        // 3 issue
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      ex(0,0,1,beef,0,0,0,0,0,0)));     // 4 resp
    vecs.push_back(mk(0,0,0,0,1,1,12,32'h55, z));                              // 5 store req
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      ex(0,1,0,0,0,0,1,1,12,32'h55)));  // 6 store issue
    vecs.push_back(mk(0,0,0,0,1,0,12,0,      z));                              // 7 load req
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      ex(0,1,0,0,0,0,1,0,12,0)));       // 8
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      ex(0,0,0,0,1,32'h55,0,0,0,0)));   // 9
    vecs.push_back(mk(0,1,5,0,0,0, 0,0,      z));                              // 10 fetch req
    vecs.push_back(mk(0,0,0,0,1,1, 5,32'hBAD,ex(1,0,0,0,0,0,1,0,5,0)));        // 11 store while busy
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      ex(0,0,1,beef,0,0,0,0,0,0)));     // 12 store dropped
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      z));                              // 13
    vecs.push_back(mk(0,0,0,0,1,0, 5,0,      z));                              // 14 load 5
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      ex(0,1,0,0,0,0,1,0,5,0)));        // 15
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      ex(0,0,0,0,1,beef,0,0,0,0)));     // 16 mem[5] intact
    vecs.push_back(mk(0,1,5,0,1,0,12,0,      z));                              // 17 both request
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      ex(0,1,0,0,0,0,1,0,12,0)));       // 18 data wins
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      ex(0,0,0,0,1,32'h55,0,0,0,0)));   // 19
    vecs.push_back(mk(0,1,5,0,0,0, 0,0,      z));                              // 20 fetch alone
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      ex(1,0,0,0,0,0,1,0,5,0)));        // 21
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      ex(0,0,1,beef,0,0,0,0,0,0)));     // 22
    vecs.push_back(mk(0,1,5,0,0,0, 0,0,      z));                              // 23 flush in resp
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      ex(1,0,0,0,0,0,1,0,5,0)));        // 24
    vecs.push_back(mk(0,0,0,1,0,0, 0,0,      z));                              // 25 rvalid suppressed
    vecs.push_back(mk(0,1,5,0,0,0, 0,0,      z));                              // 26 next fetch
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      ex(1,0,0,0,0,0,1,0,5,0)));        // 27
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      ex(0,0,1,beef,0,0,0,0,0,0)));     // 28 normal
    vecs.push_back(mk(0,1,5,0,0,0, 0,0,      z));                              // 29 flush in issue
    vecs.push_back(mk(0,0,0,1,0,0, 0,0,      ex(1,0,0,0,0,0,1,0,5,0)));        // 30
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      z));                              // 31 suppressed
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      z));                              // 32
    vecs.push_back(mk(0,0,0,1,1,0,12,0,      z));                              // 33 flush vs data
    vecs.push_back(mk(0,0,0,1,0,0, 0,0,      ex(0,1,0,0,0,0,1,0,12,0)));       // 34
    vecs.push_back(mk(0,0,0,1,0,0, 0,0,      ex(0,0,0,0,1,32'h55,0,0,0,0)));   // 35 unaffected
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      z));                              // 36
    vecs.push_back(mk(0,0,0,0,1,0,12,0,      z));                              // 37 load req
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,      ex(0,1,0,0,0,0,1,0,12,0)));       // 38 reset in issue
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      z));                              // 39 aborted
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,      z));                              // 40 no rvalid

    drive(1,0,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ifr, vecs[i].ifa, vecs[i].fl,
            vecs[i].dr, vecs[i].dwe, vecs[i].da, vecs[i].dwd);
      @(negedge clk);
      act = {if_gnt, d_gnt, if_rvalid, if_rdata, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata};
      checks++;
      if (act !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d got %h want %h", i, act, vecs[i].exp);
      end
      @(posedge clk);
      #1;
    end

    // contention: both ports requesting every cycle
    both_cnt = 0;
    drive(0,1,5,0,1,1,20,32'h77);
    for (int c = 0; c < 60 && grants.size() < 10; c++) begin
      @(negedge clk);
      if (if_gnt && d_gnt) both_cnt++;
      if (if_gnt) grants.push_back(8'h46);
      else if (d_gnt) grants.push_back(8'h44);
      @(posedge clk);
      #1;
    end
    drive(0,0,0,0,0,0,0,0);

    checks++;
    if (grants.size() != 10) begin
      errors++;
      $display("FAIL contention_grant_count got %0d want 10", grants.size());
    end
    foreach (grants[i]) begin
      exp_g = ((i % 5) == 4) ? 8'h46 : 8'h44;
      checks++;
      if (grants[i] != exp_g) begin
        errors++;
        $display("FAIL contention_grant%0d got %c want %c", i, grants[i], exp_g);
      end
    end
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL gnt_exclusive got %0d want 0", both_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL expose parameter ADDR_W, default 10, memory word-address width (1024 words).
REQ-002 SHALL expose parameter DATA_W, default 32, memory word width.
REQ-003 SHALL expose parameter MAX_WAIT, default 4, lost IF arbitrations before IF is forced to win.
REQ-004 SHALL have one clock and a synchronous, active-high reset; ports clk and rst.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 if_req  input  1  instruction-fetch read request.
REQ-008 if_addr  input  ADDR_W  fetch word address.
REQ-009 if_flush  input  1  discard any in-flight fetch response (taken branch).
REQ-010 if_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-011 if_rvalid / if_rdata  output  1 / DATA_W  fetch read data valid / value.
REQ-012 d_req, d_we  input  1, 1  data-port request; d_we=1 store, d_we=0 load.
REQ-013 d_addr, d_wdata  input  ADDR_W, DATA_W  data address, store data.
REQ-014 d_gnt  output  1  one-cycle pulse: data request accepted.
REQ-015 d_rvalid / d_rdata  output  1 / DATA_W  load data valid / value.
REQ-016 mem_en, mem_we  output  1, 1  single-port memory enable, write enable.
REQ-017 mem_addr, mem_wdata  output  ADDR_W, DATA_W  memory address, write data.
REQ-018 mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en=1, mem_we=0.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, RESP.
REQ-020 IDLE, some req high at cycle T: SHALL pick winner, enter ISSUE; mem_* and winner gnt registered, visible in T+1.
REQ-021 No req in IDLE: SHALL stay IDLE with mem_en=0.
REQ-022 Priority SHALL be data over fetch, except fetch wins when wait_cnt == MAX_WAIT.
REQ-023 wait_cnt SHALL increment (saturating at MAX_WAIT) on each arbitration where if_req=1 and data wins, and clear when fetch is granted.
REQ-024 ISSUE with write: mem_en=1, mem_we=1 for exactly one cycle; next state IDLE; no rvalid.
REQ-025 ISSUE with read: mem_en=1, mem_we=0 for one cycle; next state RESP.
REQ-026 RESP (T+2): SHALL assert winner's rvalid for one cycle with rdata = mem_rdata; next state IDLE.
REQ-027 Load-to-response latency SHALL be 2 cycles after request sampling; store occupies 2 cycles, load 3.
REQ-028 Requests SHALL be sampled only in IDLE; a req dropped before gnt SHALL be ignored with no side effects.
REQ-029 Requester SHALL hold addr/wdata/we stable until gnt; arbiter SHALL register them at arbitration.
REQ-030 if_flush=1 in ISSUE or RESP of a fetch SHALL suppress if_rvalid for that fetch; FSM timing unchanged.
REQ-031 if_flush SHALL have no effect on data transactions or on wait_cnt.
REQ-032 if_gnt and d_gnt SHALL never be high in the same cycle; at most one rvalid per cycle.
REQ-033 mem_en SHALL be 0 in IDLE and RESP.

Reset
REQ-034 rst=1 SHALL force state IDLE, wait_cnt=0, flush-pending flag 0, all outputs 0, regardless of state.
REQ-035 Reset during ISSUE or RESP SHALL abort the transaction; no rvalid or gnt SHALL follow.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the state enumeration and the default ADDR_W/DATA_W/MAX_WAIT constants.
REQ-037 One sub-module, arb_wait_counter (saturating counter with inc/clr/at_max), SHALL implement wait_cnt; the rest is flat.

Verification
REQ-038 Fetch-only: if_req=1, if_addr=5, mem[5]=0xDEADBEEF -> if_gnt at T+1, mem_en=1/addr=5 at T+1, if_rvalid=1 with 0xDEADBEEF at T+2.
REQ-039 Store then load: d_we=1, addr=12, wdata=0x55; then load addr=12 -> d_gnt each, d_rvalid with 0x55 two cycles after load sampling.
REQ-040 Contention: if_req and d_req held high continuously -> data wins 4 arbitrations, 5th goes to fetch, wait_cnt returns to 0.
REQ-041 Flush: fetch granted, if_flush=1 in RESP cycle -> if_rvalid stays 0; next request handled normally.
REQ-042 Reset mid-load: rst=1 in ISSUE of a load -> next cycle IDLE, all outputs 0, no d_rvalid ever issued.
